// File: rtl/fifo_pkt_reader_if.sv
// FIFO read port and downstream byte stream of the packet reader.
// master = the reader, slave = the FIFO plus downstream side.
interface fifo_pkt_reader_if;
    logic       fifo_empty;
    logic [9:0] fifo_data;
    logic       fifo_rd;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_sop;
    logic       m_eop;
    logic       m_abort;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd, m_valid, m_data, m_sop, m_eop,
        output m_abort
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd, m_valid, m_data, m_sop, m_eop,
        input  m_abort
    );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Read-side FIFO controller: credit-based reads, framing check,
// 2-entry skid buffer and valid/ready byte output.
module fifo_pkt_reader #(
    parameter int MAX_LEN = 32,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    fifo_pkt_reader_if.master bus,
    output logic              err_frame,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, PKT, DROP} state_e;

    typedef struct packed {
        logic       abort;
        logic       eop;
        logic       sop;
        logic [7:0] data;
    } ent_t;

    localparam logic [7:0] LAST = 8'(MAX_LEN - 1);

    state_e           state_q, state_d;
    logic [7:0]       len_q, len_d;
    logic             inflight_q;
    logic [1:0]       occ_q, occ_d;
    ent_t             buf0_q, buf0_d;
    ent_t             buf1_q, buf1_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q;

    logic       cap;
    logic       pop;
    logic       store;
    logic       w_sop;
    logic       w_eop;
    logic [2:0] credit;
    ent_t       ent;

    assign cap    = inflight_q;
    assign w_sop  = bus.fifo_data[9];
    assign w_eop  = bus.fifo_data[8];
    assign pop    = bus.m_valid & bus.m_ready;
    assign credit = {2'b00, inflight_q} + {1'b0, occ_q}
                  - {2'b00, pop};

    // rst gate keeps the read strobe low while the FIFO side is flushed
    assign bus.fifo_rd = !rst & !bus.fifo_empty
                       & (credit < 3'd2);

    assign bus.m_valid = (occ_q != 2'd0);
    assign bus.m_data  = buf0_q.data;
    assign bus.m_sop   = buf0_q.sop;
    assign bus.m_eop   = buf0_q.eop;
    assign bus.m_abort = buf0_q.abort;

    assign err_frame = err_q;
    assign pkt_count = cnt_q;
    assign busy      = inflight_q | (occ_q != 2'd0)
                     | (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        store    = 1'b0;
        err_d    = 1'b0;
        ent      = '0;
        ent.data = bus.fifo_data[7:0];
        ent.eop  = w_eop;
        if (cap) begin
            unique case (state_q)
                IDLE, PKT: begin
                    if (w_sop) begin
                        store   = 1'b1;
                        ent.sop = 1'b1;
                        len_d   = 8'd1;
                        err_d   = (state_q == PKT);
                        state_d = w_eop ? IDLE : PKT;
                    end else if (state_q == IDLE) begin
                        err_d = 1'b1;
                    end else if (w_eop) begin
                        store   = 1'b1;
                        state_d = IDLE;
                    end else if (len_q == LAST) begin
                        store     = 1'b1;
                        ent.eop   = 1'b1;
                        ent.abort = 1'b1;
                        err_d     = 1'b1;
                        state_d   = DROP;
                    end else begin
                        store = 1'b1;
                        len_d = len_q + 8'd1;
                    end
                end
                DROP: begin
                    if (w_eop) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // head of the queue always sits in buf0
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        unique case ({pop, store})
            2'b10: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd0) begin
                    buf0_d = ent;
                end else begin
                    buf1_d = ent;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = ent;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = ent;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= 8'd0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            inflight_q <= bus.fifo_rd;
            occ_q      <= occ_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            err_q      <= err_d;
            if (pop && buf0_q.eop && !buf0_q.abort) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench: FIFO model, word-level framing model, scoreboard
// and literal per-test expectations.
module tb_fifo_pkt_reader;
    localparam int ML = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err_frame;
    logic [15:0] pkt_count;
    logic        busy;

    fifo_pkt_reader_if bus();

    fifo_pkt_reader #(.MAX_LEN(ML), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_frame (err_frame),
        .pkt_count (pkt_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [9:0]  fq[$];
    bit          fst[$];
    logic [10:0] exq[$];
    logic [10:0] obs[$];
    bit          inf_b = 0;
    bit          inf_st = 0;
    int          occ_b = 0;
    int          exp_err = 0;
    int          err_seen = 0;
    int          exp_cnt = 0;
    bit          m_in = 0;
    bit          m_drop = 0;
    int          m_len = 0;
    bit          prev_stall = 0;
    logic [10:0] prev_out = '0;
    int          first_rd = 0;
    int          first_val = 0;
    int          last_val = 0;
    int          n_rd = 0;
    int          n_val = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference framing rules applied in FIFO order
    task automatic put(input logic [9:0] w);
        bit s;
        bit e;
        bit st;
        logic [10:0] x;
        s  = w[9];
        e  = w[8];
        st = 0;
        x  = {1'b0, e, 1'b0, w[7:0]};
        if (m_drop) begin
            if (e) m_drop = 0;
        end else if (s) begin
            if (m_in) exp_err++;
            st    = 1;
            x[8]  = 1'b1;
            m_len = 1;
            m_in  = !e;
        end else if (!m_in) begin
            exp_err++;
        end else if (e) begin
            st   = 1;
            m_in = 0;
        end else if (m_len + 1 == ML) begin
            st      = 1;
            x[10:9] = 2'b11;
            exp_err++;
            m_in   = 0;
            m_drop = 1;
        end else begin
            st = 1;
            m_len++;
        end
        if (st) exq.push_back(x);
        fq.push_back(w);
        fst.push_back(st);
    endtask

    // FIFO read port plus bench-side credit bookkeeping
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            inf_b = 0;
            occ_b = 0;
        end else begin
            if (inf_b && inf_st) occ_b++;
            if (bus.m_valid && bus.m_ready) occ_b--;
            inf_b = 0;
            if (bus.fifo_rd) begin
                checks++;
                if (fq.size() == 0) begin
                    fails++;
                    $display("FAIL rd_on_empty actual=1 required=0");
                end else begin
                    bus.fifo_data <= fq.pop_front();
                    inf_st = fst.pop_front();
                    inf_b  = 1;
                end
            end
        end
    end

    always @(negedge clk) bus.fifo_empty = (fq.size() == 0);

    always @(negedge clk) begin
        logic [10:0] cur;
        logic [10:0] e;
        bit pop;
        #1;
        if (rst) begin
            prev_stall = 0;
        end else begin
            pop = bus.m_valid && bus.m_ready;
            chk("pkt_count", pkt_count, exp_cnt);
            chk("m_valid", bus.m_valid, occ_b != 0);
            chk("fifo_rd", bus.fifo_rd, !bus.fifo_empty
                && (int'(inf_b) + occ_b - int'(pop) < 2));
            if (err_frame) err_seen++;
            if (bus.fifo_rd) begin
                if (n_rd == 0) first_rd = cyc;
                n_rd++;
            end
            cur = {bus.m_abort, bus.m_eop, bus.m_sop, bus.m_data};
            if (prev_stall) begin
                chk("valid_held", bus.m_valid, 1);
                chk("data_stable", cur, prev_out);
            end
            prev_stall = 0;
            if (bus.m_valid) begin
                if (n_val == 0) first_val = cyc;
                last_val = cyc;
                n_val++;
                if (pop) begin
                    checks++;
                    if (exq.size() == 0) begin
                        fails++;
                        $display("FAIL spurious_byte actual=%0h required=none",
                                 cur);
                    end else begin
                        e = exq.pop_front();
                        chk("byte", cur, e);
                        obs.push_back(cur);
                        if (e[9] && !e[10]) exp_cnt++;
                    end
                end else begin
                    prev_stall = 1;
                    prev_out   = cur;
                end
            end
        end
    end

    task automatic start_test();
        obs.delete();
        exp_err  = 0;
        err_seen = 0;
        n_rd     = 0;
        n_val    = 0;
    endtask

    task automatic drain(input string nm, input bit toggle);
        int k;
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        k = 0;
        while ((exq.size() != 0 || fq.size() != 0 || busy)
               && k < 300) begin
            if (toggle) bus.m_ready = pat[k % 4];
            @(posedge clk);
            #1;
            k++;
        end
        bus.m_ready = 1'b1;
        checks++;
        if (k >= 300) begin
            fails++;
            $display("FAIL %s drain_timeout actual=%0d required=<300",
                     nm, k);
        end
        repeat (3) @(posedge clk);
        #1;
        chk({nm, " err_model"}, err_seen, exp_err);
        chk({nm, " busy_idle"}, busy, 0);
    endtask

    task automatic chk_obs(input string nm, input logic [10:0] want[$]);
        chk({nm, " n_bytes"}, obs.size(), want.size());
        for (int i = 0; i < want.size() && i < obs.size(); i++) begin
            chk({nm, " out"}, obs[i], want[i]);
        end
    endtask

    initial begin
        logic [10:0] want[$];
        int t0;
        int k;
        bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst m_valid", bus.m_valid, 0);
        chk("rst fifo_rd", bus.fifo_rd, 0);
        chk("rst busy", busy, 0);
        chk("rst pkt_count", pkt_count, 0);
        chk("rst err_frame", err_frame, 0);
        chk("rst m_flags", {bus.m_sop, bus.m_eop, bus.m_abort}, 0);
        chk("rst m_data", bus.m_data, 0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;

        // single packet, full throughput
        start_test();
        t0 = exp_cnt;
        put(10'h2A1);
        put(10'h0B2);
        put(10'h0C3);
        put(10'h1D4);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t1 busy_active", busy, 1);
        drain("t1", 0);
        want = '{11'h1A1, 11'h0B2, 11'h0C3, 11'h2D4};
        chk_obs("t1", want);
        chk("t1 n_rd", n_rd, 4);
        chk("t1 latency", first_val - first_rd, 2);
        chk("t1 no_bubble", last_val - first_val, 3);
        chk("t1 n_val", n_val, 4);
        chk("t1 pkts", pkt_count, t0 + 1);
        chk("t1 errs", err_seen, 0);

        // 8-byte packet under backpressure
        start_test();
        t0 = exp_cnt;
        put(10'h210);
        for (int i = 1; i < 7; i++) put(10'(8'h10 + i));
        put(10'h117);
        drain("t2", 1);
        want = '{11'h110, 11'h011, 11'h012, 11'h013,
                 11'h014, 11'h015, 11'h016, 11'h217};
        chk_obs("t2", want);
        chk("t2 pkts", pkt_count, t0 + 1);

        // orphan word then single-byte packet
        start_test();
        t0 = exp_cnt;
        put(10'h055);
        put(10'h377);
        drain("t3", 0);
        want = '{11'h377};
        chk_obs("t3", want);
        chk("t3 errs", err_seen, 1);
        chk("t3 pkts", pkt_count, t0 + 1);

        // length limit: 10-byte packet truncated at byte ML
        start_test();
        t0 = exp_cnt;
        put(10'h220);
        for (int i = 1; i < 9; i++) put(10'(8'h20 + i));
        put(10'h129);
        put(10'h231);
        put(10'h132);
        drain("t4", 0);
        want = '{11'h120, 11'h021, 11'h022, 11'h023, 11'h024,
                 11'h025, 11'h026, 11'h627, 11'h131, 11'h232};
        chk_obs("t4", want);
        chk("t4 errs", err_seen, 1);
        chk("t4 pkts", pkt_count, t0 + 1);

        // SOP inside a packet restarts it
        start_test();
        t0 = exp_cnt;
        put(10'h240);
        put(10'h041);
        put(10'h250);
        put(10'h051);
        put(10'h152);
        drain("t5", 0);
        want = '{11'h140, 11'h041, 11'h150, 11'h051, 11'h252};
        chk_obs("t5", want);
        chk("t5 errs", err_seen, 1);
        chk("t5 pkts", pkt_count, t0 + 1);

        // async reset with data buffered and a read in flight
        start_test();
        bus.m_ready = 1'b0;
        put(10'h260);
        put(10'h061);
        put(10'h062);
        put(10'h163);
        k = 0;
        while (!bus.m_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("t6 setup_valid", bus.m_valid, 1);
        chk("t6 setup_busy", busy, 1);
        #2;
        rst = 1'b1;
        fq.delete();
        fst.delete();
        exq.delete();
        inf_b      = 0;
        occ_b      = 0;
        m_in       = 0;
        m_drop     = 0;
        exp_cnt    = 0;
        prev_stall = 0;
        #1;
        chk("t6 rst m_valid", bus.m_valid, 0);
        chk("t6 rst fifo_rd", bus.fifo_rd, 0);
        chk("t6 rst busy", busy, 0);
        chk("t6 rst pkt_count", pkt_count, 0);
        chk("t6 rst err", err_frame, 0);
        chk("t6 rst m_out",
            {bus.m_abort, bus.m_eop, bus.m_sop, bus.m_data}, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        start_test();
        put(10'h270);
        put(10'h071);
        put(10'h172);
        drain("t6", 0);
        want = '{11'h170, 11'h071, 11'h272};
        chk_obs("t6", want);
        chk("t6 pkts", pkt_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
